// File: rtl/strange_counter_pkg.sv
// Shared constants for the strange_counter lab-board block: hex font and
// digit anode patterns, both active-low.
package strange_counter_pkg;

  localparam int NUM_DIGITS = 4;

  // Entry N is the segment pattern for hex nibble N; bit7 (dp) stays high.
  localparam logic [15:0][7:0] SEG_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Entry N drives digit N low; digit 0 is the rightmost.
  localparam logic [3:0][3:0] AN_PATTERN = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

endpackage : strange_counter_pkg

// File: rtl/strange_counter_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern (dp off).
module hex_to_seg
  import strange_counter_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule : hex_to_seg

// File: rtl/strange_counter.sv
// 16-bit step/load counter driven by board buttons, shown in hex on a
// 4-digit multiplexed common-anode display.
module strange_counter
  import strange_counter_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       BTN0,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic [7:0] SW,
  output logic [3:0] AN,
  output logic [7:0] SEG
);

  localparam int PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);

  logic          btn2_s1_q, btn2_s2_q, btn2_s3_q;
  logic          btn3_s1_q, btn3_s2_q;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    nibble;

  // Load dominates: a step edge arriving during a load is dropped, not deferred.
  always_comb begin
    count_d = count_q;
    if (btn3_s2_q) begin
      count_d = {SW, 8'h00};
    end else if (btn2_s2_q && !btn2_s3_q) begin
      count_d = count_q + {8'h00, SW};
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (BTN0) begin
      btn2_s1_q <= 1'b0;
      btn2_s2_q <= 1'b0;
      btn2_s3_q <= 1'b0;
      btn3_s1_q <= 1'b0;
      btn3_s2_q <= 1'b0;
      count_q   <= 16'h0000;
      presc_q   <= '0;
      digit_q   <= 2'd0;
    end else begin
      btn2_s1_q <= BTN2;
      btn2_s2_q <= btn2_s1_q;
      btn2_s3_q <= btn2_s2_q;
      btn3_s1_q <= BTN3;
      btn3_s2_q <= btn3_s1_q;
      count_q   <= count_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
    end
  end

  always_comb begin
    nibble = count_q[3:0];
    case (digit_q)
      2'd0: nibble = count_q[3:0];
      2'd1: nibble = count_q[7:4];
      2'd2: nibble = count_q[11:8];
      2'd3: nibble = count_q[15:12];
      default: nibble = count_q[3:0];
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (SEG)
  );

  assign AN = AN_PATTERN[digit_q];

endmodule : strange_counter

// File: tb/tb_strange_counter.sv
// Directed bench for strange_counter: count is recovered by decoding the
// scanned display, plus exact step latency on the count register.
module tb_strange_counter;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       BTN0, BTN2, BTN3;
  logic [7:0] SW;
  logic [3:0] AN;
  logic [7:0] SEG;

  int checks = 0;
  int errors = 0;

  logic [7:0]  font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0]  an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0]  seen_seg [4];
  logic [15:0] seen_val;

  strange_counter #(.DIGIT_CYCLES(DC)) dut (
    .clk  (clk),
    .BTN0 (BTN0),
    .BTN2 (BTN2),
    .BTN3 (BTN3),
    .SW   (SW),
    .AN   (AN),
    .SEG  (SEG)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [4:0] seg2nib(input logic [7:0] s);
    for (int i = 0; i < 16; i++) if (font[i] == s) return 5'(i);
    return 5'h10;
  endfunction

  function automatic int an2idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (an_exp[i] == a) return i;
    return -1;
  endfunction

  // Watch one full scan and rebuild the 16-bit value from the segments.
  task automatic read_display(input string tag);
    int bad;
    int idx;
    logic [4:0] n;
    bad = 0;
    for (int d = 0; d < 4; d++) seen_seg[d] = 8'h00;
    for (int c = 0; c < 4 * DC; c++) begin
      @(negedge clk);
      idx = an2idx(AN);
      if (idx < 0) bad++;
      else seen_seg[idx] = SEG;
    end
    seen_val = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      n = seg2nib(seen_seg[d]);
      if (n[4]) bad++;
      seen_val[d*4 +: 4] = n[3:0];
    end
    check({tag, "_scan_ok"}, 32'(bad), 32'd0);
  endtask

  task automatic press(input logic [7:0] sw);
    SW   = sw;
    BTN2 = 1'b1;
    cycles(10);
    BTN2 = 1'b0;
    cycles(10);
  endtask

  task automatic do_reset(input int n);
    BTN0 = 1'b1;
    cycles(n);
    BTN0 = 1'b0;
  endtask

  initial begin
    int k;
    int found;
    BTN0 = 1'b1; BTN2 = 1'b0; BTN3 = 1'b0; SW = 8'h00;

    // Reset and hold-after-release
    cycles(500);
    check("rst_an", 32'(AN), 32'h0000000E);
    check("rst_seg", 32'(SEG), 32'h000000C0);
    BTN0 = 1'b0;
    cycles(1);
    check("rel_an", 32'(AN), 32'h0000000E);
    check("rel_seg", 32'(SEG), 32'h000000C0);
    read_display("rst");
    check("rst_count", 32'(seen_val), 32'h0000);

    // Single step: exact 3-edge latency, one step for a long hold
    SW = 8'hD8;
    BTN2 = 1'b1;
    cycles(2);
    check("step_lat2", 32'(dut.count_q), 32'h0000);
    cycles(1);
    check("step_lat3", 32'(dut.count_q), 32'h00D8);
    cycles(47);
    BTN2 = 1'b0;
    cycles(5);
    read_display("step");
    check("step_count", 32'(seen_val), 32'h00D8);
    check("step_dig0", 32'(seen_seg[0]), 32'h80);
    check("step_dig1", 32'(seen_seg[1]), 32'hA1);
    check("step_dig2", 32'(seen_seg[2]), 32'hC0);
    check("step_dig3", 32'(seen_seg[3]), 32'hC0);

    // Four presses from zero
    do_reset(3);
    cycles(2);
    for (int i = 0; i < 4; i++) press(8'hD8);
    read_display("rep");
    check("rep_count", 32'(seen_val), 32'h0360);

    // Load then wrap
    SW = 8'hFF;
    BTN3 = 1'b1;
    cycles(5);
    BTN3 = 1'b0;
    cycles(4);
    read_display("load");
    check("load_count", 32'(seen_val), 32'hFF00);
    press(8'hFF);
    read_display("wrap1");
    check("wrap1_count", 32'(seen_val), 32'hFFFF);
    press(8'hFF);
    read_display("wrap2");
    check("wrap2_count", 32'(seen_val), 32'h00FE);

    // Load and step together: load wins, step discarded
    SW = 8'h12;
    BTN2 = 1'b1;
    BTN3 = 1'b1;
    cycles(5);
    BTN2 = 1'b0;
    BTN3 = 1'b0;
    cycles(5);
    read_display("prio");
    check("prio_count", 32'(seen_val), 32'h1200);

    // A load pulse between edges is never sampled
    SW = 8'h55;
    #1 BTN3 = 1'b1;
    #3 BTN3 = 1'b0;
    cycles(5);
    read_display("glitch");
    check("glitch_count", 32'(seen_val), 32'h1200);

    // Scan order and per-phase segments with count=1200
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (AN == 4'b0111) found = 1;
    end
    for (int c = 0; c < 40 && found == 1; c++) begin
      @(negedge clk);
      if (AN == 4'b1110) found = 2;
    end
    check("scan_sync", 32'(found), 32'd2);
    for (k = 0; k < 5 * DC; k++) begin
      logic [15:0] cv;
      int d;
      cv = 16'h1200;
      d = (k / DC) % 4;
      check($sformatf("scan_an_%0d", k), 32'(AN), 32'(an_exp[d]));
      check($sformatf("scan_seg_%0d", k), 32'(SEG), 32'(font[cv[d*4 +: 4]]));
      check($sformatf("scan_onecold_%0d", k), 32'($countones(~AN)), 32'd1);
      @(negedge clk);
    end

    // Button held through reset counts as a fresh press afterwards
    SW = 8'h01;
    BTN2 = 1'b1;
    cycles(5);
    do_reset(3);
    cycles(6);
    BTN2 = 1'b0;
    cycles(2);
    read_display("rsthold");
    check("rsthold_count", 32'(seen_val), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_strange_counter
